zap_reset_sequencer: RTL and testbench

Staged reset release and warm-reset controller sitting directly downstream of the main reset synchronizer. It takes the synchronized system reset (assertion asynchronous, deassertion already clock-aligned) and releases per-domain resets in a fixed order: memory/bus, then cache/MMU, then core. It also handles warm resets: software or watchdog requests drain the bus and re-enter the same release sequence. A sticky cause code is kept for software to read.

---
 rtl/zap_reset_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_zap_reset_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_reset_sequencer.sv
// ---------------------------------------------------------------------------
// zap_reset_sequencer
//
// Staged reset release and warm-reset controller. It sits directly after the
// main reset synchronizer. Domain resets are released in a fixed order:
// memory/bus, then cache/MMU, then core. A software or watchdog request
// seen in RUN first drains the bus, then re-enters the same sequence.
// A sticky cause code and a sticky drain-timeout flag are kept for software.
//
// Parameters
//   HOLD_CYCLES    cycles all resets stay asserted after entering HOLD (>=1)
//   STAGE_GAP      cycles between successive domain releases (>=1)
//   DRAIN_TIMEOUT  maximum cycles spent waiting for bus idle (>=1)
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset_n        asynchronous active-low reset (synchronized deassertion)
//   i_sw_reset_req   software warm-reset request, single-cycle pulse
//   i_wdog_timeout   watchdog expiry, single-cycle pulse
//   i_mem_idle       bus/memory subsystem has no outstanding transactions
//   o_mem_reset      active-high reset, memory/bus domain
//   o_cache_reset    active-high reset, cache/MMU domain
//   o_core_reset     active-high reset, core pipeline
//   o_drain_req      request to bus masters to stop issuing and drain
//   o_seq_done       all domains released, normal running
//   o_reset_cause    00 external/power-on, 01 software, 10 watchdog
//   o_drain_timeout  sticky: last drain ended by timeout rather than idle
// ---------------------------------------------------------------------------
module zap_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned STAGE_GAP     = 4,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sw_reset_req,
  input  logic       i_wdog_timeout,
  input  logic       i_mem_idle,
  output logic       o_mem_reset,
  output logic       o_cache_reset,
  output logic       o_core_reset,
  output logic       o_drain_req,
  output logic       o_seq_done,
  output logic [1:0] o_reset_cause,
  output logic       o_drain_timeout
);

  localparam int unsigned MAX_HS = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_P  = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  typedef enum logic [2:0] {
    S_HOLD,
    S_REL_MEM,
    S_REL_CACHE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic       r_mem_reset,     w_mem_reset_nxt;
  logic       r_cache_reset,   w_cache_reset_nxt;
  logic       r_core_reset,    w_core_reset_nxt;
  logic       r_drain_req,     w_drain_req_nxt;
  logic       r_seq_done,      w_seq_done_nxt;
  logic [1:0] r_reset_cause,   w_reset_cause_nxt;
  logic       r_drain_timeout, w_drain_timeout_nxt;

  logic w_req;

  assign w_req = i_sw_reset_req | i_wdog_timeout;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= S_HOLD;
      r_cnt           <= '0;
      r_mem_reset     <= 1'b1;
      r_cache_reset   <= 1'b1;
      r_core_reset    <= 1'b1;
      r_drain_req     <= 1'b0;
      r_seq_done      <= 1'b0;
      r_reset_cause   <= CAUSE_EXT;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_mem_reset     <= w_mem_reset_nxt;
      r_cache_reset   <= w_cache_reset_nxt;
      r_core_reset    <= w_core_reset_nxt;
      r_drain_req     <= w_drain_req_nxt;
      r_seq_done      <= w_seq_done_nxt;
      r_reset_cause   <= w_reset_cause_nxt;
      r_drain_timeout <= w_drain_timeout_nxt;
    end
  end

  // Outputs are computed one cycle ahead and registered, so every transition
  // below describes the value seen right after the edge that takes it.
  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_mem_reset_nxt     = r_mem_reset;
    w_cache_reset_nxt   = r_cache_reset;
    w_core_reset_nxt    = r_core_reset;
    w_drain_req_nxt     = r_drain_req;
    w_seq_done_nxt      = r_seq_done;
    w_reset_cause_nxt   = r_reset_cause;
    w_drain_timeout_nxt = r_drain_timeout;

    case (r_state)
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt       = '0;
          w_mem_reset_nxt = 1'b0;
          w_state_nxt     = S_REL_MEM;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_REL_MEM: begin
        if (r_cnt == STAGE_LAST) begin
          w_cnt_nxt         = '0;
          w_cache_reset_nxt = 1'b0;
          w_state_nxt       = S_REL_CACHE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_REL_CACHE: begin
        if (r_cnt == STAGE_LAST) begin
          w_cnt_nxt        = '0;
          w_core_reset_nxt = 1'b0;
          w_seq_done_nxt   = 1'b1;
          w_state_nxt      = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_RUN: begin
        if (w_req) begin
          w_drain_req_nxt   = 1'b1;
          w_seq_done_nxt    = 1'b0;
          w_cnt_nxt         = '0;
          // Watchdog has priority when both pulses land in the same cycle.
          w_reset_cause_nxt = i_wdog_timeout ? CAUSE_WDOG : CAUSE_SW;
          w_state_nxt       = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (i_mem_idle || (r_cnt == DRAIN_LAST)) begin
          w_mem_reset_nxt     = 1'b1;
          w_cache_reset_nxt   = 1'b1;
          w_core_reset_nxt    = 1'b1;
          w_drain_req_nxt     = 1'b0;
          w_cnt_nxt           = '0;
          // Idle wins over a coincident timeout: the drain did complete.
          w_drain_timeout_nxt = ~i_mem_idle;
          w_state_nxt         = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt       = S_HOLD;
        w_cnt_nxt         = '0;
        w_mem_reset_nxt   = 1'b1;
        w_cache_reset_nxt = 1'b1;
        w_core_reset_nxt  = 1'b1;
        w_drain_req_nxt   = 1'b0;
        w_seq_done_nxt    = 1'b0;
      end
    endcase
  end

  assign o_mem_reset     = r_mem_reset;
  assign o_cache_reset   = r_cache_reset;
  assign o_core_reset    = r_core_reset;
  assign o_drain_req     = r_drain_req;
  assign o_seq_done      = r_seq_done;
  assign o_reset_cause   = r_reset_cause;
  assign o_drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_zap_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_zap_reset_sequencer
//
// Directed bench for zap_reset_sequencer. One instance uses the default
// parameters; a second uses HOLD_CYCLES=1, STAGE_GAP=1, DRAIN_TIMEOUT=4 to
// cover the minimum-parameter corner. Both share clock and inputs.
// Outputs are packed into an 8-bit status word
// {mem, cache, core, drain_req, seq_done, cause[1:0], drain_timeout}.
// ---------------------------------------------------------------------------
module tb_zap_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_req;
  logic wdog;
  logic mem_idle;

  logic       a_mem, a_cache, a_core, a_drain, a_done, a_dto;
  logic [1:0] a_cause;
  logic       b_mem, b_cache, b_core, b_drain, b_done, b_dto;
  logic [1:0] b_cause;

  logic [7:0] st_a;
  logic [7:0] st_b;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  zap_reset_sequencer #(
    .HOLD_CYCLES  (16),
    .STAGE_GAP    (4),
    .DRAIN_TIMEOUT(256)
  ) u_dut_a (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_sw_reset_req (sw_req),
    .i_wdog_timeout (wdog),
    .i_mem_idle     (mem_idle),
    .o_mem_reset    (a_mem),
    .o_cache_reset  (a_cache),
    .o_core_reset   (a_core),
    .o_drain_req    (a_drain),
    .o_seq_done     (a_done),
    .o_reset_cause  (a_cause),
    .o_drain_timeout(a_dto)
  );

  zap_reset_sequencer #(
    .HOLD_CYCLES  (1),
    .STAGE_GAP    (1),
    .DRAIN_TIMEOUT(4)
  ) u_dut_b (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_sw_reset_req (sw_req),
    .i_wdog_timeout (wdog),
    .i_mem_idle     (mem_idle),
    .o_mem_reset    (b_mem),
    .o_cache_reset  (b_cache),
    .o_core_reset   (b_core),
    .o_drain_req    (b_drain),
    .o_seq_done     (b_done),
    .o_reset_cause  (b_cause),
    .o_drain_timeout(b_dto)
  );

  assign st_a = {a_mem, a_cache, a_core, a_drain, a_done, a_cause, a_dto};
  assign st_b = {b_mem, b_cache, b_core, b_drain, b_done, b_cause, b_dto};

  function automatic logic [7:0] st(input logic mem, input logic cache, input logic core,
                                    input logic drain, input logic done,
                                    input logic [1:0] cause, input logic dto);
    return {mem, cache, core, drain, done, cause, dto};
  endfunction

  // Expected status e edges after HOLD entry (or after reset release).
  function automatic logic [7:0] rel_st(input int unsigned e, input int unsigned h,
                                        input int unsigned g, input logic [1:0] cause,
                                        input logic dto);
    return st(e < h, e < h + g, e < h + 2*g, 1'b0, e >= h + 2*g, cause, dto);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b (mem,cache,core,drain,done,cause,dto) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks the 24 edges of a default release sequence on instance A.
  // A software pulse is applied before edge inj (0 = none) to show it is dropped.
  task automatic expect_release(input string tag, input logic [1:0] cause,
                                input logic dto, input int unsigned inj);
    for (int unsigned e = 1; e <= 24; e++) begin
      if (e == inj) sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      check($sformatf("%s_e%0d", tag, e), st_a, rel_st(e, 16, 4, cause, dto));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    sw_req   = 1'b0;
    wdog     = 1'b0;
    mem_idle = 1'b1;

    // Power-on
    repeat (5) tick();
    check("por_reset_a", st_a, st(1, 1, 1, 0, 0, 2'b00, 0));
    check("por_reset_b", st_b, st(1, 1, 1, 0, 0, 2'b00, 0));
    rst_n = 1'b1;
    expect_release("por", 2'b00, 1'b0, 0);
    tick();
    check("run_idle", st_a, st(0, 0, 0, 0, 1, 2'b00, 0));

    // Software reset, bus idle
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("sw_drain", st_a, st(0, 0, 0, 1, 0, 2'b01, 0));
    tick();
    check("sw_hold", st_a, st(1, 1, 1, 0, 0, 2'b01, 0));
    expect_release("sw", 2'b01, 1'b0, 0);

    // Watchdog, bus busy: drain runs to timeout
    mem_idle = 1'b0;
    wdog = 1'b1;
    tick();
    wdog = 1'b0;
    check("wd_drain", st_a, st(0, 0, 0, 1, 0, 2'b10, 0));
    for (int unsigned e = 1; e <= 255; e++) begin
      tick();
      check($sformatf("wd_wait_%0d", e), st_a, st(0, 0, 0, 1, 0, 2'b10, 0));
    end
    tick();
    check("wd_timeout", st_a, st(1, 1, 1, 0, 0, 2'b10, 1));
    mem_idle = 1'b1;
    expect_release("wd", 2'b10, 1'b1, 0);

    // Simultaneous pulses; idle drain clears timeout flag; sw pulse in REL_CACHE dropped
    sw_req = 1'b1;
    wdog   = 1'b1;
    tick();
    sw_req = 1'b0;
    wdog   = 1'b0;
    check("both_drain", st_a, st(0, 0, 0, 1, 0, 2'b10, 1));
    tick();
    check("both_hold", st_a, st(1, 1, 1, 0, 0, 2'b10, 0));
    expect_release("both", 2'b10, 1'b0, 22);
    tick();
    check("both_run", st_a, st(0, 0, 0, 0, 1, 2'b10, 0));

    // Async reset mid-drain at cnt=100
    mem_idle = 1'b0;
    wdog = 1'b1;
    tick();
    wdog = 1'b0;
    repeat (100) tick();
    check("mid_drain", st_a, st(0, 0, 0, 1, 0, 2'b10, 0));
    rst_n = 1'b0;
    #1;
    check("async_a", st_a, st(1, 1, 1, 0, 0, 2'b00, 0));
    check("async_b", st_b, st(1, 1, 1, 0, 0, 2'b00, 0));
    repeat (3) tick();
    mem_idle = 1'b1;
    rst_n = 1'b1;
    for (int unsigned e = 1; e <= 24; e++) begin
      tick();
      check($sformatf("por2_a_e%0d", e), st_a, rel_st(e, 16, 4, 2'b00, 1'b0));
      if (e <= 4)
        check($sformatf("por2_b_e%0d", e), st_b, rel_st(e, 1, 1, 2'b00, 1'b0));
    end

    // Minimum-parameter instance: warm reset with idle bus
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("b_sw_drain", st_b, st(0, 0, 0, 1, 0, 2'b01, 0));
    tick();
    check("b_sw_hold", st_b, st(1, 1, 1, 0, 0, 2'b01, 0));
    for (int unsigned e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("b_sw_e%0d", e), st_b, rel_st(e, 1, 1, 2'b01, 1'b0));
    end

    // Minimum-parameter instance: drain timeout after 4 cycles
    mem_idle = 1'b0;
    wdog = 1'b1;
    tick();
    wdog = 1'b0;
    check("b_wd_drain", st_b, st(0, 0, 0, 1, 0, 2'b10, 0));
    for (int unsigned e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("b_wd_wait_%0d", e), st_b, st(0, 0, 0, 1, 0, 2'b10, 0));
    end
    tick();
    check("b_wd_timeout", st_b, st(1, 1, 1, 0, 0, 2'b10, 1));
    tick();
    check("b_wd_rel_mem", st_b, st(0, 1, 1, 0, 0, 2'b10, 1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
